// File: rtl/adc_polling_rx.sv
// adc_polling_rx: SPI master that sweeps an 8-channel 12-bit serial ADC
// (ADC128S022-style). It keeps one result per channel in a register bank.
// SCLK comes from a clock-enable divider on clk_core. The address sent in
// frame k selects the sample returned in frame k+1, so a sweep is N_CH+1
// frames long and the last frame carries a dummy address 0.
// Ports:
//   clk_core, rst_n   core clock, asynchronous active-low reset
//   en                sweep request (sampled in IDLE and at the end of a sweep)
//   miso              ADC serial data out
//   sclk, mosi, cs_n  SPI bus (sclk idles high, cs_n active low)
//   data_out          result bank, slot i at [i*DATA_W +: DATA_W]
//   valid, ch         one-cycle slot-write strobe and the slot index
//   sweep_done        one-cycle pulse on the write of the last slot
//   busy              high from sweep start until the final gap ends
module adc_polling_rx #(
   parameter int unsigned CLK_DIV   = 14,
   parameter int unsigned N_CH      = 8,
   parameter int unsigned FRAME_LEN = 16,
   parameter int unsigned DATA_W    = 12,
   parameter int unsigned GAP       = 4
) (
   input  logic                   clk_core,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   miso,
   output logic                   sclk,
   output logic                   mosi,
   output logic                   cs_n,
   output logic [N_CH*DATA_W-1:0] data_out,
   output logic                   valid,
   output logic [2:0]             ch,
   output logic                   sweep_done,
   output logic                   busy
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
   localparam int unsigned HP_W  = $clog2(2 * FRAME_LEN + 1);
   localparam int unsigned GAP_W = $clog2(GAP + 1);
   localparam int unsigned K_W   = $clog2(N_CH + 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_STOP, S_GAP} state_t;

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         cnt, cnt_nxt;
   logic [HP_W-1:0]          hp, hp_nxt;
   logic [GAP_W-1:0]         gap, gap_nxt;
   logic [K_W-1:0]           k, k_nxt;
   logic [FRAME_LEN-1:0]     tx, tx_nxt;
   logic [FRAME_LEN-1:0]     shift, shift_nxt;
   logic                     sclk_nxt, mosi_nxt, cs_n_nxt, busy_nxt;
   logic                     valid_nxt, done_nxt;
   logic [2:0]               ch_nxt;
   logic [N_CH*DATA_W-1:0]   data_nxt;
   logic                     tc, hp_last, gap_last, last_frame;

   assign tc         = (cnt == '0);
   assign hp_last    = (hp == HP_W'(2 * FRAME_LEN - 1));
   assign gap_last   = (gap == GAP_W'(GAP - 1));
   assign last_frame = (k == K_W'(N_CH));

   // Control word {2'b00, addr, zeros}; the last frame of a sweep sends address 0
   function automatic logic [FRAME_LEN-1:0] ctrl_word(input logic [K_W-1:0] idx);
      logic [FRAME_LEN-1:0] w;
      logic [2:0]           a;
      a = (idx == K_W'(N_CH)) ? 3'd0 : 3'(idx);
      w = '0;
      w[FRAME_LEN-3 -: 3] = a;
      return w;
   endfunction

   // State register
   always_ff @(posedge clk_core or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; every advance outside IDLE waits for the half-period terminal count
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (en) state_nxt = S_START;
         S_START: if (tc) state_nxt = S_SHIFT;
         S_SHIFT: if (tc && hp_last) state_nxt = S_STOP;
         S_STOP:  if (tc) state_nxt = S_GAP;
         S_GAP: begin
            if (tc && gap_last) begin
               if (!last_frame || en) state_nxt = S_START;
               else                   state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      cnt_nxt   = (state == S_IDLE || tc) ? CNT_W'(CLK_DIV - 1) : CNT_W'(cnt - CNT_W'(1));
      hp_nxt    = hp;
      gap_nxt   = gap;
      k_nxt     = k;
      tx_nxt    = tx;
      shift_nxt = shift;
      sclk_nxt  = sclk;
      mosi_nxt  = mosi;
      cs_n_nxt  = cs_n;
      busy_nxt  = busy;
      data_nxt  = data_out;
      ch_nxt    = ch;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (en) begin
               k_nxt    = '0;
               tx_nxt   = ctrl_word(K_W'(0));
               mosi_nxt = tx_nxt[FRAME_LEN-1];
               cs_n_nxt = 1'b0;
               busy_nxt = 1'b1;
            end
         end
         S_START: begin
            // First falling edge re-drives the word MSB
            if (tc) begin
               sclk_nxt = 1'b0;
               hp_nxt   = '0;
               mosi_nxt = tx[FRAME_LEN-1];
            end
         end
         S_SHIFT: begin
            if (tc) begin
               hp_nxt = HP_W'(hp + HP_W'(1));
               if (!hp[0]) begin
                  sclk_nxt  = 1'b1;
                  shift_nxt = FRAME_LEN'({shift, miso});
               end else if (!hp_last) begin
                  sclk_nxt = 1'b0;
                  tx_nxt   = tx << 1;
                  mosi_nxt = tx[FRAME_LEN-2];
               end
            end
         end
         S_STOP: begin
            // Frame k returns the sample addressed in frame k-1; frame 0 is discarded
            if (tc) begin
               cs_n_nxt = 1'b1;
               mosi_nxt = 1'b0;
               gap_nxt  = '0;
               if (k != '0) begin
                  valid_nxt = 1'b1;
                  done_nxt  = last_frame;
                  ch_nxt    = 3'(k - K_W'(1));
                  for (int i = 0; i < int'(N_CH); i++) begin
                     if (k == K_W'(i + 1)) data_nxt[i*DATA_W +: DATA_W] = shift[DATA_W-1:0];
                  end
               end
            end
         end
         S_GAP: begin
            if (tc) begin
               gap_nxt = GAP_W'(gap + GAP_W'(1));
               if (gap_last) begin
                  if (!last_frame || en) begin
                     k_nxt    = last_frame ? K_W'(0) : K_W'(k + K_W'(1));
                     tx_nxt   = ctrl_word(k_nxt);
                     mosi_nxt = tx_nxt[FRAME_LEN-1];
                     cs_n_nxt = 1'b0;
                  end else begin
                     k_nxt    = '0;
                     busy_nxt = 1'b0;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // Registered datapath and outputs
   always_ff @(posedge clk_core or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= CNT_W'(CLK_DIV - 1);
         hp         <= '0;
         gap        <= '0;
         k          <= '0;
         tx         <= '0;
         shift      <= '0;
         sclk       <= 1'b1;
         mosi       <= 1'b0;
         cs_n       <= 1'b1;
         busy       <= 1'b0;
         data_out   <= '0;
         ch         <= 3'd0;
         valid      <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         hp         <= hp_nxt;
         gap        <= gap_nxt;
         k          <= k_nxt;
         tx         <= tx_nxt;
         shift      <= shift_nxt;
         sclk       <= sclk_nxt;
         mosi       <= mosi_nxt;
         cs_n       <= cs_n_nxt;
         busy       <= busy_nxt;
         data_out   <= data_nxt;
         ch         <= ch_nxt;
         valid      <= valid_nxt;
         sweep_done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_adc_polling_rx.sv
// Testbench for adc_polling_rx: behavioural ADC on the SPI pins plus a
// scoreboard of expected frames (address sent) and slot writes.
module tb_adc_polling_rx;
   localparam int unsigned CLK_DIV   = 2;
   localparam int unsigned N_CH      = 8;
   localparam int unsigned FRAME_LEN = 16;
   localparam int unsigned DATA_W    = 12;
   localparam int unsigned GAP       = 4;
   localparam int unsigned FRAME_LOW = 34 * CLK_DIV;
   localparam int unsigned GAP_CYC   = GAP * CLK_DIV;
   localparam int          BUDGET    = 3000;

   logic                   clk_core = 1'b0;
   logic                   rst_n, en, miso;
   logic                   sclk, mosi, cs_n, valid, sweep_done, busy;
   logic [2:0]             ch;
   logic [N_CH*DATA_W-1:0] data_out;

   always #5 clk_core = ~clk_core;

   adc_polling_rx #(
      .CLK_DIV(CLK_DIV), .N_CH(N_CH), .FRAME_LEN(FRAME_LEN), .DATA_W(DATA_W), .GAP(GAP)
   ) dut (
      .clk_core(clk_core), .rst_n(rst_n), .en(en), .miso(miso),
      .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .data_out(data_out),
      .valid(valid), .ch(ch), .sweep_done(sweep_done), .busy(busy)
   );

   typedef struct packed { logic [2:0] ch; logic [DATA_W-1:0] data; } exp_t;
   typedef struct packed { logic [2:0] addr; logic has_valid; } frm_t;

   exp_t              exp_q[$];
   frm_t              frm_q[$];
   logic [DATA_W-1:0] bank [N_CH];

   int          checks = 0, failures = 0;
   int          cs_low_cnt = 0, rise_cnt = 0, fall_j = 0, hi_cnt = 0;
   int          sclk_err = 0, mosi_err = 0, stray_err = 0;
   logic        prev_cs_n = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0;
   logic        gap_armed = 1'b0, upper_mode = 1'b0;
   logic [2:0]  adc_sel = 3'd0;
   logic [15:0] tx_word = '0, rx_word = '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N_CH*DATA_W-1:0] bank_vec();
      logic [N_CH*DATA_W-1:0] v;
      for (int i = 0; i < int'(N_CH); i++) v[i*DATA_W +: DATA_W] = bank[i];
      return v;
   endfunction

   task automatic push_sweep();
      frm_t f;
      exp_t e;
      for (int i = 0; i <= int'(N_CH); i++) begin
         f.addr      = (i == int'(N_CH)) ? 3'd0 : 3'(i);
         f.has_valid = (i != 0);
         frm_q.push_back(f);
      end
      for (int i = 0; i < int'(N_CH); i++) begin
         e.ch   = 3'(i);
         e.data = upper_mode ? 12'h123 : 12'(12'hA00 + i);
         exp_q.push_back(e);
      end
   endtask

   task automatic frame_end();
      frm_t f;
      chk("cs_low_cycles", 128'(cs_low_cnt), 128'(FRAME_LOW));
      chk("sclk_rises", 128'(rise_cnt), 128'(16));
      chk("frame_expected", 128'(frm_q.size() != 0), 128'(1));
      if (frm_q.size() != 0) begin
         f = frm_q.pop_front();
         chk("mosi_word", 128'(rx_word), 128'({2'b00, f.addr, 11'b0}));
         chk("valid_at_frame_end", 128'(valid), 128'(f.has_valid));
      end
      adc_sel   = rx_word[13:11];
      gap_armed = (frm_q.size() != 0);
      hi_cnt    = 1;
   endtask

   task automatic check_valid();
      exp_t e;
      int   idx;
      chk("valid_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         idx = int'(e.ch);
         chk("ch", 128'(ch), 128'(e.ch));
         chk("slot_data", 128'(data_out[idx*DATA_W +: DATA_W]), 128'(e.data));
         chk("sweep_done", 128'(sweep_done), 128'(e.ch == 3'(N_CH - 1)));
         bank[idx] = e.data;
         chk("bank_hold", 128'(data_out), 128'(bank_vec()));
      end
   endtask

   // One core cycle: ADC model, timing monitor and scoreboard, all at the falling clk edge
   task automatic step();
      @(negedge clk_core);
      if (!cs_n) begin
         if (prev_cs_n) begin
            if (gap_armed) chk("gap_cycles", 128'(hi_cnt), 128'(GAP_CYC));
            gap_armed  = 1'b0;
            cs_low_cnt = 0;
            rise_cnt   = 0;
            fall_j     = 0;
            rx_word    = '0;
            tx_word    = upper_mode ? 16'hF123 : {4'h0, 8'hA0, 1'b0, adc_sel};
            miso       = tx_word[15];
         end
         cs_low_cnt++;
         if (prev_sclk && !sclk) begin
            if (fall_j < 16) miso = tx_word[4'(15 - fall_j)];
            fall_j++;
         end
         if (!prev_sclk && sclk) begin
            rise_cnt++;
            rx_word = {rx_word[14:0], mosi};
            if (mosi !== prev_mosi) mosi_err++;
         end
      end else begin
         hi_cnt++;
         if (sclk !== 1'b1) sclk_err++;
         if (!prev_cs_n) frame_end();
      end
      if (valid) check_valid();
      else if (sweep_done) stray_err++;
      prev_cs_n = cs_n;
      prev_sclk = sclk;
      prev_mosi = mosi;
   endtask

   task automatic wait_sweep(input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while ((busy || frm_q.size() != 0 || exp_q.size() != 0) && n < BUDGET);
      chk({tag, "_completed"}, 128'(n < BUDGET), 128'(1));
      repeat (4) step();
      chk({tag, "_busy_low"}, 128'(busy), 128'(0));
      chk({tag, "_cs_n_idle"}, 128'(cs_n), 128'(1));
      chk({tag, "_bank"}, 128'(data_out), 128'(bank_vec()));
      chk({tag, "_sclk_high_when_idle"}, 128'(sclk_err), 128'(0));
      chk({tag, "_mosi_stable"}, 128'(mosi_err), 128'(0));
      chk({tag, "_no_stray_done"}, 128'(stray_err), 128'(0));
   endtask

   task automatic pulse_en();
      en = 1'b1;
      step();
      en = 1'b0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      en    = 1'b0;
      miso  = 1'b0;
      for (int i = 0; i < int'(N_CH); i++) bank[i] = '0;

      // Reset values while en toggles
      for (int i = 0; i < 6; i++) begin
         en = ~en;
         step();
      end
      en = 1'b0;
      chk("rst_sclk", 128'(sclk), 128'(1));
      chk("rst_cs_n", 128'(cs_n), 128'(1));
      chk("rst_mosi", 128'(mosi), 128'(0));
      chk("rst_data", 128'(data_out), 128'(0));
      chk("rst_valid", 128'(valid), 128'(0));
      chk("rst_done", 128'(sweep_done), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      rst_n = 1'b1;
      repeat (3) step();

      // Single sweep from a one-cycle en pulse
      push_sweep();
      pulse_en();
      wait_sweep("single");

      // Bits above DATA_W are dropped
      upper_mode = 1'b1;
      push_sweep();
      pulse_en();
      wait_sweep("upper");
      upper_mode = 1'b0;

      // Continuous mode: en held across the sweep boundary
      push_sweep();
      push_sweep();
      en = 1'b1;
      n  = 0;
      while (exp_q.size() > int'(N_CH) - 1 && n < BUDGET) begin
         step();
         n++;
      end
      chk("cont_second_sweep_started", 128'(n < BUDGET), 128'(1));
      en = 1'b0;
      wait_sweep("continuous");

      // Asynchronous reset in the middle of SHIFT of frame 3
      push_sweep();
      pulse_en();
      n = 0;
      while (!(frm_q.size() == int'(N_CH) + 1 - 3 && !cs_n && rise_cnt >= 2) && n < BUDGET) begin
         step();
         n++;
      end
      chk("midreset_reached_frame3", 128'(n < BUDGET), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("async_sclk", 128'(sclk), 128'(1));
      chk("async_cs_n", 128'(cs_n), 128'(1));
      chk("async_mosi", 128'(mosi), 128'(0));
      chk("async_data", 128'(data_out), 128'(0));
      chk("async_valid", 128'(valid), 128'(0));
      chk("async_busy", 128'(busy), 128'(0));
      exp_q.delete();
      frm_q.delete();
      for (int i = 0; i < int'(N_CH); i++) bank[i] = '0;
      prev_cs_n = 1'b1;
      prev_sclk = 1'b1;
      prev_mosi = 1'b0;
      gap_armed = 1'b0;
      #2;
      rst_n = 1'b1;
      repeat (3) step();
      push_sweep();
      pulse_en();
      wait_sweep("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_polling_rx.md
Name: adc_polling_rx

Overview:
- SPI master that polls an 8-channel, 12-bit serial ADC (ADC128S022-style protocol) and stores one result per channel in a register bank.
- Receive-side counterpart of the DAC polling transmitter; runs on clk_core and generates SCLK internally with a clock-enable divider, not a derived clock.
- Each sweep reads every channel once. The channel address sent in frame k selects the sample returned in frame k+1.

Parameters:
- CLK_DIV, 14, clk_core cycles per SCLK half-period (>=2)
- N_CH, 8, channels per sweep (<=8, 3-bit address)
- FRAME_LEN, 16, SCLK cycles per frame
- DATA_W, 12, result width (LSBs of the received frame)
- GAP, 4, SCLK half-periods with cs_n high between frames (>=1)

Ports:
- clk_core  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  sweep request, sampled in IDLE
- miso  in  1  ADC serial data out
- sclk  out  1  SPI clock, idles high
- mosi  out  1  ADC serial data in (control word)
- cs_n  out  1  ADC chip select, active low
- data_out  out  N_CH*DATA_W  result bank, slot i at [i*DATA_W +: DATA_W]
- valid  out  1  one-cycle pulse when a slot is written
- ch  out  3  index of the slot written with valid
- sweep_done  out  1  one-cycle pulse after the last slot of a sweep
- busy  out  1  high from sweep start until the final GAP ends

Behaviour:
- Reset is asynchronous. Every output takes its reset value immediately, including mid-frame: sclk=1, cs_n=1, mosi=0, data_out=0, valid=0, ch=0, sweep_done=0, busy=0. FSM goes to IDLE and the frame index clears to 0.
- FSM states: IDLE -> START -> SHIFT -> STOP -> GAP -> (START | IDLE). A half-period counter counts CLK_DIV-1 down to 0; each state advance occurs at terminal count.
- IDLE: when en=1 on a clk_core edge, then next cycle cs_n=0, busy=1, frame index k=0, enter START.
- Control word for frame k: {2'b00, addr[2:0], 11'b0}, sent MSB first, with addr = k mod N_CH.
- START: lasts CLK_DIV cycles. cs_n=0, sclk=1, mosi = word bit 15.
- SHIFT: 2*FRAME_LEN half-periods.
  - Falling edge j (j=0..15): mosi updates to word bit 15-j. Bit 15 is re-driven at j=0.
  - Rising edge: on the same clk_core cycle sclk goes 1, miso shifts into a 16-bit register, MSB first.
  - After the 16th rising edge, enter STOP.
- STOP: lasts CLK_DIV cycles with sclk=1 and cs_n=0. On exit, cs_n=1 and mosi=0.
- Result handling on the first GAP cycle, for frame k>=1:
  - The slot written is k-1: slot k-1 <= shift[DATA_W-1:0], valid=1, ch=k-1.
  - Frame 0 data is discarded with no valid.
  - Bits above DATA_W are ignored.
- GAP: lasts GAP*CLK_DIV cycles, cs_n=1, sclk=1.
  - k<N_CH: k++ and go to START.
  - k==N_CH: this is the last frame. It carries address 0 as a dummy and returns slot N_CH-1. sweep_done pulses on the same cycle as that last valid.
  - At the end of the last GAP: if en=1, restart with k=0 (continuous mode); otherwise busy=0 and go to IDLE.
- Frames per sweep: N_CH+1. cs_n-low time per frame = 34*CLK_DIV cycles. Frame period = (34+GAP)*CLK_DIV cycles.
- en deasserted mid-sweep: the sweep completes, with no truncation.
- data_out slots not being written hold their value. No slot is written outside valid.
- sclk, mosi and cs_n are registered outputs. No combinational path exists from miso to any output except through the shift register.

Test Plan:
- Reset values: hold rst_n=0 and toggle en -> sclk=1, cs_n=1, mosi=0, data_out=0, valid/sweep_done/busy=0.
- Single sweep (CLK_DIV=2, GAP=4): en pulsed for 1 cycle; ADC model returns {4'h0, 8'hA0, addr_prev} -> 9 frames; mosi address sequence 0..7,0; valid pulses with ch=0..7; slot i = 12'hA00+i; sweep_done coincides with the ch=7 valid; busy low afterwards.
- Timing (CLK_DIV=2): measure per frame -> cs_n low for exactly 68 clk_core cycles, 16 sclk rising edges, sclk high whenever cs_n=1, mosi stable across each rising edge.
- Continuous mode: en held high -> second sweep's cs_n falls GAP*CLK_DIV cycles after the first sweep's last frame STOP; frame 0 of the new sweep produces no valid.
- Async reset mid-SHIFT of frame 3: assert rst_n=0 -> outputs reach reset values with no clock edge; after release and en=1, the sweep restarts from address 0 and all slots rewrite correctly.
- Upper bits ignored: ADC returns 16'hF123 -> slot = 12'h123.
